// File: rtl/adder_accum_pkg.sv
// Shared definitions for the operand accumulator: FSM state encoding, operation
// modes and small helpers that decode a mode into its add/sub and wrap/saturate parts.
package adder_accum_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [1:0] MODE_ADD_WRAP = 2'b00;
   localparam logic [1:0] MODE_ADD_SAT  = 2'b01;
   localparam logic [1:0] MODE_SUB_WRAP = 2'b10;
   localparam logic [1:0] MODE_SUB_SAT  = 2'b11;

   function automatic logic is_subtract(input logic [1:0] m);
      return (m == MODE_SUB_WRAP) || (m == MODE_SUB_SAT);
   endfunction

   function automatic logic is_saturate(input logic [1:0] m);
      return (m == MODE_ADD_SAT) || (m == MODE_SUB_SAT);
   endfunction

endpackage

// File: rtl/adder_accum_alu.sv
// Combinational add/subtract step of the accumulator, one bit wider than the
// operands so carry and borrow fall out as the top bit; saturating modes clamp.
module adder_accum_alu
   import adder_accum_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] a,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] next_acc,
   output logic             flag
);

   logic [WIDTH:0] wide;
   logic           subtract;
   logic           saturate;

   always_comb begin
      subtract = is_subtract(mode);
      saturate = is_saturate(mode);
      if (subtract) begin
         wide = {1'b0, acc} - {1'b0, a};
      end else begin
         wide = {1'b0, acc} + {1'b0, a};
      end
      flag     = wide[WIDTH];
      next_acc = wide[WIDTH-1:0];
      // A borrow clamps to zero, a carry clamps to all-ones.
      if (saturate && flag) begin
         next_acc = subtract ? '0 : '1;
      end
   end

endmodule

// File: rtl/adder_accum.sv
// Accumulates COUNT operands per group with a latched mode, then holds the
// result and sticky overflow flag until the consumer takes it.
module adder_accum
   import adder_accum_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int COUNT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ena,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             ovf
);

   localparam int             CW   = $clog2(COUNT + 1);
   localparam logic [CW-1:0]  LAST = CW'(COUNT);
   localparam logic [CW-1:0]  ONE  = CW'(1);

   state_t           state;
   state_t           state_next;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_inc;
   logic [WIDTH-1:0] acc;
   logic [1:0]       mode_q;
   logic [WIDTH-1:0] alu_next;
   logic             alu_flag;
   logic             accept;
   logic             deliver;
   logic             group_done;

   adder_accum_alu #(.WIDTH(WIDTH)) alu (
      .acc      (acc),
      .a        (a),
      .mode     (mode_q),
      .next_acc (alu_next),
      .flag     (alu_flag)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      count_inc  = count + ONE;
      group_done = (count_inc == LAST);
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = (COUNT == 1) ? HOLD : ACCUM;
         ACCUM:   if (accept && group_done) state_next = HOLD;
         HOLD:    if (deliver) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The output handshake deliberately ignores ena so a stalled producer never blocks the consumer.
   always_comb begin
      in_ready  = ena && (state != HOLD) && !reset;
      out_valid = (state == HOLD);
      accept    = in_valid && in_ready;
      deliver   = out_valid && out_ready;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc    <= '0;
         count  <= '0;
         mode_q <= MODE_ADD_WRAP;
         z      <= '0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  acc    <= a;
                  count  <= ONE;
                  mode_q <= mode;
                  ovf    <= 1'b0;
                  if (COUNT == 1) z <= a;
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc   <= alu_next;
                  count <= count_inc;
                  ovf   <= ovf | alu_flag;
                  if (group_done) z <= alu_next;
               end
            end
            HOLD: begin
               if (deliver) count <= '0;
            end
            default: begin
               count <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/adder_accum.md
ADDER_ACCUM -- requirements
Module: adder_accum

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; SHALL be >= 2.
REQ-002 Parameter COUNT, default 4: operands summed per result; SHALL be >= 1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 ena  input  1  block enable; low SHALL stall the input side.
REQ-006 in_valid  input  1  operand a is valid.
REQ-007 in_ready  output  1  block accepts an operand this cycle.
REQ-008 a  input  WIDTH  unsigned operand.
REQ-009 mode  input  2  operation, where 00 = add/wrap, 01 = add/saturate, 10 = subtract/wrap, 11 = subtract/saturate.
REQ-010 out_valid  output  1  result z and flag ovf are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 z  output  WIDTH  registered result.
REQ-013 ovf  output  1  sticky overflow/borrow for the current group.

Function
REQ-014 FSM states SHALL be IDLE, ACCUM and HOLD.
REQ-015 in_ready SHALL be ena AND (state != HOLD) AND NOT reset, decoded combinationally.
REQ-016 An accept SHALL occur on in_valid AND in_ready.
REQ-017 Accept in IDLE: acc = a, ovf = 0, count = 1, mode latched; next state SHALL be ACCUM, or HOLD if COUNT = 1.
REQ-018 Accept in ACCUM SHALL compute acc = acc op a using the latched mode and increment count; when count reaches COUNT the next state SHALL be HOLD.
REQ-019 Changes on the mode input after the first accept of a group SHALL be ignored until the next group.
REQ-020 Arithmetic SHALL be WIDTH+1 bits wide; a carry-out on add or a borrow on subtract SHALL set ovf, and ovf SHALL stay set until the next group starts.
REQ-021 In wrap modes, acc SHALL take the low WIDTH bits.
REQ-022 In saturate modes, acc SHALL clamp to all-ones on carry and to zero on borrow.
REQ-023 Once acc has saturated, later operands SHALL still be applied to the clamped value.
REQ-024 In HOLD: out_valid = 1, z = acc; z and ovf SHALL remain stable while out_ready is low.
REQ-025 Output handshake out_valid AND out_ready SHALL return the FSM to IDLE on the next cycle, with out_valid low.
REQ-026 No same-cycle bypass: minimum period SHALL be COUNT+1 cycles per result.
REQ-027 ena low SHALL hold acc, count, state and the latched mode.
REQ-028 The output handshake SHALL still complete while ena is low.
REQ-029 in_valid outside an accept SHALL have no effect.
REQ-030 The count register SHALL be $clog2(COUNT+1) bits wide and SHALL never wrap.

Reset
REQ-031 While reset is high on a clock edge, the next state SHALL be: state = IDLE, acc = 0, count = 0, latched mode = 00, z = 0, ovf = 0, out_valid = 0.
REQ-032 Reset SHALL take priority over ena and over both handshakes.
REQ-033 Reset asserted mid-group or in HOLD SHALL discard the partial or pending result, with no output handshake.

Structure
REQ-034 Package adder_accum_pkg SHALL hold the FSM state encoding and the four mode constants.
REQ-035 A combinational sub-module adder_accum_alu (inputs acc, a, mode; outputs next_acc, flag) SHALL hold the add/subtract and saturation logic.
REQ-036 adder_accum SHALL contain only the FSM, the counter and the registers.

Verification (WIDTH=8, COUNT=4, ena=1 unless stated)
REQ-037 Mode 00, operands 10, 20, 30, 40 on back-to-back cycles, out_ready high -> out_valid on the cycle after the 4th accept, z=100, ovf=0; one cycle later IDLE with in_ready=1.
REQ-038 Mode 00, operands 200, 100, 0, 0 -> z=44, ovf=1. Mode 01, operands 200, 100, 5, 0 -> z=255, ovf=1.
REQ-039 Mode 10, operands 50, 20, 40, 0 -> z=246, ovf=1. Mode 11, same operands -> z=0, ovf=1. Mode toggled to 00 after the 1st operand -> results unchanged.
REQ-040 Result pending with out_ready low for 5 cycles and in_valid high -> in_ready=0; z and ovf constant; no accept. Then out_ready=1 -> next group's first operand accepted 2 cycles later.
REQ-041 ena low for 3 cycles between operands 2 and 3 (in_valid high) -> no accepts and acc held; final sum correct. ena low while in HOLD -> output handshake still completes.
REQ-042 reset pulsed for 1 cycle after 2 accepted operands -> out_valid=0, z=0; next group 1, 2, 3, 4 -> z=10, ovf=0.
